// File: rtl/posit_sqrt_encode.sv
// Posit encode-and-round stage behind the square-root datapath: packs regime/exponent/mantissa
// fields into a posit word with round-to-nearest-even and saturation, over a 2-stage pipeline.
package posit_pkg;
    typedef enum logic [1:0] {POSIT32, POSIT16, POSIT8, POSIT64} posit_format_e;

    function automatic int posit_width(posit_format_e f);
        case (f)
            POSIT16: return 16;
            POSIT8:  return 8;
            POSIT64: return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int exp_bits(posit_format_e f);
        case (f)
            POSIT16: return 1;
            POSIT8:  return 1;
            POSIT64: return 3;
            default: return 2;
        endcase
    endfunction
endpackage

module posit_sqrt_encode #(
    parameter posit_pkg::posit_format_e pFormat = posit_pkg::posit_format_e'(0),
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             zero_i,
    input  logic             nar_i,
    input  logic [posit_pkg::exp_bits(pFormat)-1:0]      exp_i,
    input  logic [$clog2(posit_pkg::posit_width(pFormat))+4:0] regime_len_i,
    input  logic             regime_neg_i,
    input  logic [2*posit_pkg::posit_width(pFormat)-1:0] mant_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [posit_pkg::posit_width(pFormat)-1:0]   posit_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int N  = posit_pkg::posit_width(pFormat);
    localparam int ES = posit_pkg::exp_bits(pFormat);
    localparam int RS = $clog2(N);
    localparam int FW = ES + 2*N - 1;
    localparam int BW = N - 1 + FW;

    localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};

    typedef struct packed {
        logic [N-2:0]     trunc;
        logic             guard;
        logic             sticky;
        logic             sat;
        logic             neg;
        logic             zero;
        logic             nar;
        logic [TAG_W-1:0] tag;
    } s1_t;

    s1_t          s1_d, s1_q;
    logic         s1_valid_q, s2_valid_q;
    logic [N-1:0] posit_d, posit_q;
    logic [TAG_W-1:0] tag_q;
    logic         s2_adv;
    logic [BW-1:0] fill, keep, tail, body;
    logic         up;
    logic [N-1:0] res;
    logic         unused_hidden;

    assign unused_hidden = mant_i[2*N-1];

    assign s2_adv      = !s2_valid_q || out_ready_i;
    assign in_ready_o  = !s1_valid_q || s2_adv;
    assign out_valid_o = s2_valid_q;
    assign posit_o     = posit_q;
    assign tag_o       = tag_q;

    // Body is left-aligned: the top regime_len bits are the run, the terminator and the
    // exponent/fraction tail follow immediately after, shifted down by the run length.
    always_comb begin
        fill = {BW{~regime_neg_i}};
        keep = ~({BW{1'b1}} >> regime_len_i);
        tail = {regime_neg_i, exp_i, mant_i[2*N-2:0], {(N-2){1'b0}}};
        body = (fill & keep) | (tail >> regime_len_i);

        s1_d        = '0;
        s1_d.trunc  = body[BW-1 -: N-1];
        s1_d.guard  = body[BW-N];
        s1_d.sticky = |body[BW-N-1:0];
        s1_d.sat    = regime_len_i >= (RS+5)'(N-1);
        s1_d.neg    = regime_neg_i;
        s1_d.zero   = zero_i;
        s1_d.nar    = nar_i;
        s1_d.tag    = tag_i;
    end

    always_comb begin
        up  = s1_q.guard && (s1_q.sticky || s1_q.trunc[0]);
        res = {1'b0, s1_q.trunc} + N'(up);
        posit_d = res;
        if (s1_q.nar)           posit_d = NAR;
        else if (s1_q.zero)     posit_d = '0;
        else if (s1_q.sat)      posit_d = s1_q.neg ? MINPOS : MAXPOS;
        else if (res[N-1])      posit_d = MAXPOS;
        else if (res == '0)     posit_d = MINPOS;
    end

    always_ff @(posedge clk_i) begin
        if (in_valid_i && in_ready_o) s1_q <= s1_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            posit_q    <= '0;
            tag_q      <= '0;
        end else begin
            if (flush_i) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
            end else begin
                if (in_ready_o) s1_valid_q <= in_valid_i;
                if (s2_adv)     s2_valid_q <= s1_valid_q;
            end
            if (s2_adv && s1_valid_q && !flush_i) begin
                posit_q <= posit_d;
                tag_q   <= s1_q.tag;
            end
        end
    end
endmodule
